cpu_mem_access_unit: RTL and testbench
======================================

Name: cpu_mem_access_unit

Overview:
- Multi-cycle successor to the single-cycle memory-access stage.
- Sits in the MEM pipeline slot and drives an SRAM-like request/response data bus (req/addr_ok/data_ok) instead of assuming a same-cycle RAM.
- Covers alignment exceptions, store-data lane steering, load extension and LWL/LWR merge, pipeline stall generation, flush draining and an optional bus-timeout error.

Parameters:
- ADDR_W, 32, bus address width; bits [1:0] give the byte offset.
- SUPPORT_UNALIGNED, 1, 1 = decode LWL/LWR/SWL/SWR; 0 = treat them as non-memory ops.
- TIMEOUT_CYCLES, 0, 0 = no timeout; N>0 = raise bus error after N cycles in WAIT.
- EX_AEL, 6'h04, exception code for load/fetch address error.
- EX_AES, 6'h05, exception code for store address error.
- EX_BUSERR, 6'h07, exception code for data bus error/timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the current instruction
- in_valid  in  1  MEM-stage instruction present; inputs held stable while stall_req=1
- in_op  in  6  instruction opcode [31:26]
- in_addr  in  ADDR_W  effective address
- in_wdata  in  32  store data (rt)
- in_rt_old  in  32  old rt value for LWL/LWR merge
- in_exr_valid  in  1  upstream exception already pending
- stall_req  out  1  hold pipeline
- out_valid  out  1  result/completion pulse
- out_rdata  out  32  extended/merged load data
- exr_valid  out  1  new exception from this stage
- exr_type  out  6  exception code
- exr_badvaddr  out  ADDR_W  faulting address
- bus_req  out  1  request valid
- bus_wr  out  1  1 = store
- bus_addr  out  ADDR_W  {in_addr[ADDR_W-1:2],2'b00}
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-steered store data
- bus_addr_ok  in  1  request accepted this cycle
- bus_data_ok  in  1  response valid this cycle
- bus_rdata  in  32  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, DRAIN, DONE. Reset → IDLE; all outputs 0; timeout counter 0.
- mem_op = in_valid & opcode is a load/store & !in_exr_valid & !flush & no alignment fault.
- Alignment faults, combinational in IDLE:
  - LH/LHU/SH with addr[0]≠0.
  - LW/SW with addr[1:0]≠0.
  - Result: exr_valid=1, exr_type=EX_AEL (loads) or EX_AES (stores), exr_badvaddr=in_addr, no bus request, stall_req=0.
- Non-memory ops or in_exr_valid: out_valid=in_valid the same cycle, out_rdata=0, stall_req=0.
- IDLE & mem_op → REQ next cycle. stall_req=1 from the accepting cycle until the DONE cycle (exclusive).
- REQ: bus_req=1; bus_addr/bus_wr/bus_wstrb/bus_wdata driven from registered copies of the inputs.
  - addr_ok → WAIT (stores also wait for data_ok as the write acknowledge).
- WAIT: counter increments each cycle.
  - data_ok → DONE; load data captured into out_rdata after extension/merge.
  - If TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES before data_ok: exr_valid=1 for one cycle with exr_type=EX_BUSERR and exr_badvaddr=address; → DRAIN.
- DONE: out_valid=1 for one cycle, stall_req=0, → IDLE.
- Byte enables (sa=addr[1:0]):
  - B ops: 1<<sa; H ops: 3<<sa; W ops: 4'hF.
  - LWL/SWL: (4'hF<<sa)>>3 style, i.e. bytes 0..sa.
  - LWR/SWR: bytes sa..3.
- Store data:
  - SB: {4{b}}; SH: {2{h}}; SW: as-is.
  - SWL: in_wdata >> 8*(3-sa); SWR: in_wdata << 8*sa.
- Load data: select lane by sa, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - LWL: (rdata << 8*(3-sa)) | (rt_old & ~(32'hFFFFFFFF << 8*(3-sa))).
  - LWR: (rdata >> 8*sa) | (rt_old & ~(32'hFFFFFFFF >> 8*sa)).
- Flush behaviour:
  - Flush in REQ with no addr_ok that cycle → IDLE, bus_req drops next cycle.
  - Flush in REQ with addr_ok, or in WAIT → DRAIN.
  - DRAIN: stall_req=0, no out_valid; wait for data_ok, discard, → IDLE. A new mem_op arriving in DRAIN is held by stall_req=1 until DRAIN exits.
- Simultaneous addr_ok and data_ok in REQ: illegal on this bus (data_ok only after acceptance); the bench asserts against it.
- Reset mid-operation: → IDLE immediately; any late data_ok is ignored in IDLE.
- Stores update no register; out_rdata=0 for stores.

Test Plan:
- LW addr 0x1000, addr_ok at +1, data_ok at +3 with rdata 0x8899AABB → stall_req high 4 cycles, out_valid pulse, out_rdata=0x8899AABB.
- LB addr 0x1003, rdata 0x80112233 → wstrb=4'b1000, out_rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH addr 0x2002, wdata 0x0000BEEF → bus_wr=1, wstrb=4'b1100, bus_wdata=0xBEEFBEEF. SH at 0x2001 → exr_valid, exr_type=0x05, exr_badvaddr=0x2001, no bus_req.
- LWL addr 0x3001, rdata 0x11223344, rt_old 0xAABBCCDD → out_rdata=0x3344CCDD. LWR same → 0xAA112233.
- Flush in WAIT, data_ok two cycles later → no out_valid, state IDLE. A following LW completes normally.
- TIMEOUT_CYCLES=4, no data_ok → exr_valid pulse with type 0x07 at WAIT cycle 4. Late data_ok is drained. rst asserted in REQ → bus_req=0 next cycle.

Source files
------------

// File: rtl/cpu_mem_access_unit.sv
// cpu_mem_access_unit: multi-cycle MEM stage driving an SRAM-like req/addr_ok/data_ok bus
module cpu_mem_access_unit #(
  parameter int         ADDR_W            = 32,
  parameter bit         SUPPORT_UNALIGNED = 1'b1,
  parameter int         TIMEOUT_CYCLES    = 0,
  parameter logic [5:0] EX_AEL            = 6'h04,
  parameter logic [5:0] EX_AES            = 6'h05,
  parameter logic [5:0] EX_BUSERR         = 6'h07
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [5:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_rt_old,
  input  logic              in_exr_valid,
  output logic              stall_req,
  output logic              out_valid,
  output logic [31:0]       out_rdata,
  output logic              exr_valid,
  output logic [5:0]        exr_type,
  output logic [ADDR_W-1:0] exr_badvaddr,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LWL = 6'h22, OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SWL = 6'h2A, OP_SW = 6'h2B, OP_SWR = 6'h2E;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0] op_q, op_d;
  logic [31:0] rt_q, rt_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [3:0] wstrb_q, wstrb_d, strb;
  logic wr_q, wr_d;
  logic [1:0] sa, sa_q;
  logic is_b, is_h, is_w, is_l, is_r, is_store, is_mem, misal, fault, mem_op, free, to_hit;
  logic [31:0] wsteer, lane, ldata;
  // decode the incoming instruction: op class, alignment, lane steering for stores
  always_comb begin
    sa = in_addr[1:0];
    sa_q = addr_q[1:0];
    is_b = in_op inside {OP_LB, OP_LBU, OP_SB};
    is_h = in_op inside {OP_LH, OP_LHU, OP_SH};
    is_w = in_op inside {OP_LW, OP_SW};
    is_l = SUPPORT_UNALIGNED && (in_op inside {OP_LWL, OP_SWL});
    is_r = SUPPORT_UNALIGNED && (in_op inside {OP_LWR, OP_SWR});
    is_store = (in_op inside {OP_SB, OP_SH, OP_SW}) || (SUPPORT_UNALIGNED && (in_op inside {OP_SWL, OP_SWR}));
    is_mem = is_b | is_h | is_w | is_l | is_r;
    misal = (is_h & sa[0]) | (is_w & (sa != 2'b00));
    free = (state_q == IDLE) || (state_q == DRAIN);
    fault = in_valid & is_mem & ~in_exr_valid & ~flush & misal;
    mem_op = in_valid & is_mem & ~in_exr_valid & ~flush & ~misal;
    strb = is_b ? 4'b0001 << sa : is_h ? 4'b0011 << sa : is_l ? 4'hF >> ~sa : is_r ? 4'hF << sa : 4'hF;
    wsteer = is_b ? {4{in_wdata[7:0]}} : is_h ? {2{in_wdata[15:0]}} :
             is_l ? in_wdata >> {~sa, 3'b000} : is_r ? in_wdata << {sa, 3'b000} : in_wdata;
    to_hit = (state_q == WAIT) && !bus_data_ok && !flush && (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end
  // shape returned load data: lane select + extension, or LWL/LWR merge with old rt
  always_comb begin
    lane = bus_rdata >> {sa_q, 3'b000};
    ldata = op_q == OP_LB  ? {{24{lane[7]}}, lane[7:0]} :
            op_q == OP_LBU ? {24'b0, lane[7:0]} :
            op_q == OP_LH  ? {{16{lane[15]}}, lane[15:0]} :
            op_q == OP_LHU ? {16'b0, lane[15:0]} :
            op_q == OP_LW  ? bus_rdata :
            op_q == OP_LWL ? (bus_rdata << {~sa_q, 3'b000}) | (rt_q & ~(32'hFFFFFFFF << {~sa_q, 3'b000})) :
            op_q == OP_LWR ? (bus_rdata >> {sa_q, 3'b000}) | (rt_q & ~(32'hFFFFFFFF >> {sa_q, 3'b000})) : 32'b0;
  end
  // next state; a flush racing the response with data already back needs no drain
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    rt_d = rt_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wr_d = wr_q;
    rdata_d = rdata_q;
    cnt_d = state_q == WAIT ? cnt_q + 32'd1 : 32'd0;
    case (state_q)
      IDLE: if (mem_op) begin
        state_d = REQ;
        op_d = in_op;
        addr_d = in_addr;
        rt_d = in_rt_old;
        wdata_d = is_store ? wsteer : 32'b0;
        wstrb_d = strb;
        wr_d = is_store;
      end
      REQ: state_d = bus_addr_ok ? (flush ? DRAIN : WAIT) : (flush ? IDLE : REQ);
      WAIT: if (bus_data_ok) begin
        state_d = flush ? IDLE : DONE;
        rdata_d = ldata;
      end else if (flush || to_hit) state_d = DRAIN;
      DRAIN: state_d = bus_data_ok ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // state and captured-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      rt_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wr_q <= 1'b0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      rt_q <= rt_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
  end
  // pipeline-facing and bus-facing outputs
  always_comb begin
    stall_req = (state_q == REQ) || (state_q == WAIT) || (free && mem_op);
    out_valid = !flush && ((state_q == DONE) || (free && in_valid && (!is_mem || in_exr_valid)));
    out_rdata = state_q == DONE ? rdata_q : 32'b0;
    exr_valid = to_hit || (free && fault);
    exr_type = to_hit ? EX_BUSERR : !exr_valid ? 6'b0 : is_store ? EX_AES : EX_AEL;
    exr_badvaddr = to_hit ? addr_q : exr_valid ? in_addr : '0;
    bus_req = state_q == REQ;
    bus_wr = bus_req && wr_q;
    bus_addr = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus_wstrb = bus_req ? wstrb_q : 4'b0;
    bus_wdata = bus_req ? wdata_q : 32'b0;
  end
endmodule

// File: tb/tb_cpu_mem_access_unit.sv
// tb_cpu_mem_access_unit: directed and random checks of the MEM-stage bus unit against a byte-level model
module tb_cpu_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_exr_valid = 1'b0;
  logic [5:0] in_op = '0;
  logic [31:0] in_addr = '0, in_wdata = '0, in_rt_old = '0, bus_rdata = '0;
  logic bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic stall_req, out_valid, exr_valid, bus_req, bus_wr;
  logic [31:0] out_rdata, exr_badvaddr, bus_addr, bus_wdata;
  logic [5:0] exr_type;
  logic [3:0] bus_wstrb;
  int tests = 0, fails = 0;
  logic [5:0] ops [12];

  cpu_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rt_old(in_rt_old), .in_exr_valid(in_exr_valid), .stall_req(stall_req),
    .out_valid(out_valid), .out_rdata(out_rdata), .exr_valid(exr_valid), .exr_type(exr_type),
    .exr_badvaddr(exr_badvaddr), .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus_req && bus_addr_ok && bus_data_ok) begin
      fails++;
      $error("FAIL bus_proto: addr_ok and data_ok together while bus_req=1");
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_st(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
  endfunction

  // reference: which bytes the access touches, what lands on each bus lane, what the register receives
  task automatic model(input logic [5:0] op, input logic [31:0] a, wd, rt, rd,
                       output logic [3:0] es, output logic [31:0] ew, output logic [31:0] er, output logic st);
    int sa, lo, hi, v;
    sa = int'(a[1:0]);
    st = is_st(op);
    lo = sa;
    hi = sa;
    case (op)
      6'h21, 6'h25, 6'h29: hi = sa + 1;
      6'h23, 6'h2B: begin lo = 0; hi = 3; end
      6'h22, 6'h2A: lo = 0;
      6'h26, 6'h2E: hi = 3;
      default: ;
    endcase
    ew = '0;
    er = '0;
    for (int i = 0; i < 4; i++) begin
      es[i] = (i >= lo) && (i <= hi);
      case (op)
        6'h28: ew[8*i +: 8] = wd[7:0];
        6'h29: ew[8*i +: 8] = wd[8*(i%2) +: 8];
        6'h2B: ew[8*i +: 8] = wd[8*i +: 8];
        6'h2A: if (i <= sa) ew[8*i +: 8] = wd[8*(i+3-sa) +: 8];
        6'h2E: if (i >= sa) ew[8*i +: 8] = wd[8*(i-sa) +: 8];
        6'h22: er[8*i +: 8] = (i >= 3 - sa) ? rd[8*(i-3+sa) +: 8] : rt[8*i +: 8];
        6'h26: er[8*i +: 8] = (i <= 3 - sa) ? rd[8*(i+sa) +: 8] : rt[8*i +: 8];
        default: ;
      endcase
    end
    case (op)
      6'h20: begin v = int'(rd[8*sa +: 8]); if (v > 127) v -= 256; er = 32'(v); end
      6'h24: er = 32'(rd[8*sa +: 8]);
      6'h21: begin v = int'(rd[8*sa +: 16]); if (v > 32767) v -= 65536; er = 32'(v); end
      6'h25: er = 32'(rd[8*sa +: 16]);
      6'h23: er = rd;
      default: ;
    endcase
  endtask

  // one full access: accept cycle, al cycles until addr_ok, response at cycle dl, then completion
  task automatic run_mem(input logic [5:0] op, input logic [31:0] a, wd, rt, rd, input int al, input int dl);
    logic [3:0] es;
    logic [31:0] ew, er;
    logic st;
    model(op, a, wd, rt, rd, es, ew, er, st);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd; in_rt_old = rt;
    in_exr_valid = 1'b0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1;
    chk("acc_stall", 32'(stall_req), 1);
    chk("acc_breq", 32'(bus_req), 0);
    chk("acc_exr", 32'(exr_valid), 0);
    for (int c = 1; c <= dl; c++) begin
      @(negedge clk);
      bus_addr_ok = (c == al);
      bus_data_ok = (c == dl);
      bus_rdata = (c == dl) ? rd : $urandom;
      #1;
      chk("busy_stall", 32'(stall_req), 1);
      chk("busy_ovalid", 32'(out_valid), 0);
      chk("busy_breq", 32'(bus_req), 32'(c <= al));
      if (c == al) begin
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_wr", 32'(bus_wr), 32'(st));
        chk("bus_wstrb", 32'(bus_wstrb), 32'(es));
        if (st) chk("bus_wdata", bus_wdata, ew);
      end
    end
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1;
    chk("done_ovalid", 32'(out_valid), 1);
    chk("done_rdata", out_rdata, st ? 32'b0 : er);
    chk("done_stall", 32'(stall_req), 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("after_ovalid", 32'(out_valid), 0);
    chk("after_breq", 32'(bus_req), 0);
  endtask

  task automatic run_fault(input logic [5:0] op, input logic [31:0] a);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_addr = a; in_exr_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flt_exr", 32'(exr_valid), 1);
    chk("flt_type", 32'(exr_type), is_st(op) ? 32'h05 : 32'h04);
    chk("flt_badv", exr_badvaddr, a);
    chk("flt_stall", 32'(stall_req), 0);
    chk("flt_breq", 32'(bus_req), 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("flt_breq_next", 32'(bus_req), 0);
  endtask

  task automatic run_pass(input logic [5:0] op, input logic ex);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_addr = 32'h1000; in_exr_valid = ex; flush = 1'b0;
    #1;
    chk("pass_ovalid", 32'(out_valid), 1);
    chk("pass_rdata", out_rdata, 0);
    chk("pass_stall", 32'(stall_req), 0);
    chk("pass_exr", 32'(exr_valid), 0);
    @(negedge clk);
    in_valid = 1'b0; in_exr_valid = 1'b0;
    #1;
    chk("pass_breq_next", 32'(bus_req), 0);
  endtask

  initial begin
    logic [5:0] op;
    logic [31:0] a;
    int al, dl;
    ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_exr", 32'(exr_valid), 0);
    chk("rst_breq", 32'(bus_req), 0);
    chk("rst_rdata", out_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    run_mem(6'h23, 32'h1000, 32'h0, 32'h0, 32'h8899AABB, 1, 3);
    run_mem(6'h20, 32'h1003, 32'h0, 32'h0, 32'h80112233, 1, 2);
    run_mem(6'h24, 32'h1003, 32'h0, 32'h0, 32'h80112233, 2, 3);
    run_mem(6'h29, 32'h2002, 32'h0000BEEF, 32'h0, 32'h0, 2, 4);
    run_fault(6'h29, 32'h2001);
    run_fault(6'h23, 32'h1002);
    run_fault(6'h25, 32'h0003);
    run_mem(6'h22, 32'h3001, 32'h0, 32'hAABBCCDD, 32'h11223344, 1, 2);
    run_mem(6'h26, 32'h3001, 32'h0, 32'hAABBCCDD, 32'h11223344, 1, 2);
    run_mem(6'h2A, 32'h3002, 32'hA1B2C3D4, 32'h0, 32'h0, 1, 2);
    run_mem(6'h2E, 32'h3002, 32'hA1B2C3D4, 32'h0, 32'h0, 1, 2);
    run_pass(6'h00, 1'b0);
    run_pass(6'h23, 1'b1);

    // flush while the request is still unaccepted
    @(negedge clk);
    in_valid = 1'b1; in_op = 6'h23; in_addr = 32'h4000;
    #1 chk("frq_stall", 32'(stall_req), 1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("frq_breq", 32'(bus_req), 1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("frq_breq_drop", 32'(bus_req), 0);
    chk("frq_stall_drop", 32'(stall_req), 0);

    // flush while waiting for the response, then drain it
    @(negedge clk);
    in_valid = 1'b1; in_op = 6'h23; in_addr = 32'h4004;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #1 chk("fw_breq", 32'(bus_req), 1);
    @(negedge clk);
    bus_addr_ok = 1'b0; flush = 1'b1;
    #1 chk("fw_exr", 32'(exr_valid), 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fw_drain_stall", 32'(stall_req), 0);
    chk("fw_drain_ovalid", 32'(out_valid), 0);
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1 chk("fw_late_ovalid", 32'(out_valid), 0);
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    chk("fw_idle_ovalid", 32'(out_valid), 0);
    chk("fw_idle_breq", 32'(bus_req), 0);
    run_mem(6'h23, 32'h4008, 32'h0, 32'h0, 32'h01234567, 1, 2);

    // bus timeout at the fourth WAIT cycle, late response drained, next load held meanwhile
    @(negedge clk);
    in_valid = 1'b1; in_op = 6'h23; in_addr = 32'h5000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus_addr_ok = (c == 1);
      #1;
      chk("to_exr", 32'(exr_valid), 32'(c == 5));
      if (c == 5) begin
        chk("to_type", 32'(exr_type), 32'h07);
        chk("to_badv", exr_badvaddr, 32'h5000);
      end
    end
    @(negedge clk);
    bus_addr_ok = 1'b0; in_addr = 32'h5010;
    #1;
    chk("to_drain_hold", 32'(stall_req), 1);
    chk("to_drain_breq", 32'(bus_req), 0);
    chk("to_drain_exr", 32'(exr_valid), 0);
    chk("to_drain_ovalid", 32'(out_valid), 0);
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1 chk("to_late_ovalid", 32'(out_valid), 0);
    run_mem(6'h23, 32'h5010, 32'h0, 32'h0, 32'h76543210, 1, 3);

    // reset in the middle of a request
    @(negedge clk);
    in_valid = 1'b1; in_op = 6'h23; in_addr = 32'h6000;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rr_breq", 32'(bus_req), 1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rr_breq_drop", 32'(bus_req), 0);
    chk("rr_stall", 32'(stall_req), 0);
    @(negedge clk);
    bus_data_ok = 1'b1;
    #1 chk("rr_late_ovalid", 32'(out_valid), 0);
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1 chk("rr_idle_breq", 32'(bus_req), 0);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 11)];
      a = $urandom & 32'hFFFFFFFC;
      if (op inside {6'h21, 6'h25, 6'h29}) a[1] = 1'($urandom_range(0, 1));
      else if (!(op inside {6'h23, 6'h2B})) a[1:0] = 2'($urandom_range(0, 3));
      if ((op inside {6'h21, 6'h25, 6'h29, 6'h23, 6'h2B}) && ($urandom_range(0, 4) == 0)) begin
        a[1:0] = 2'($urandom_range(1, 3));
        if (op inside {6'h21, 6'h25, 6'h29}) a[0] = 1'b1;
        run_fault(op, a);
      end else begin
        al = $urandom_range(1, 3);
        dl = al + $urandom_range(1, 3);
        run_mem(op, a, $urandom, $urandom, $urandom, al, dl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
